mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) memory arbiter with ack timeout
// Optional arbitration-loss counter enabled by MEM_ARB_PERF_EN.

module mem_arbiter #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        m_cs,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,

    output logic        if_stall,
    output logic        mem_stall,
    output logic        err,
    output logic [15:0] conflict_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] D_BUSY = 2'd1;
    localparam logic [1:0] I_BUSY = 2'd2;

    localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT);

    logic [1:0]  state_q,    state_d;
    logic        m_we_q,     m_we_d;
    logic [31:0] m_addr_q,   m_addr_d;
    logic [31:0] m_wdata_q,  m_wdata_d;
    logic        if_ack_q,   if_ack_d;
    logic        d_ack_q,    d_ack_d;
    logic        err_q,      err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q,  d_rdata_d;
    logic [7:0]  to_cnt_q,   to_cnt_d;
    logic        drop_q,     drop_d;

    logic        d_req;
    logic        d_req_eff;
    logic        if_req_eff;
    logic        cur_req;
    logic        live;

    // A request still high in the cycle its ack is presented has already been
    // served; masking it keeps the arbiter from replaying the same access.
    assign d_req      = d_ren | d_wen;
    assign d_req_eff  = d_req & ~d_ack_q;
    assign if_req_eff = if_req & ~if_ack_q;

    assign cur_req = (state_q == D_BUSY) ? d_req : if_req;
    assign live    = cur_req & ~drop_q;

    always_comb begin
        state_d    = state_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        to_cnt_d   = to_cnt_q;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                to_cnt_d = 8'd0;
                drop_d   = 1'b0;
                if (d_req_eff) begin
                    state_d   = D_BUSY;
                    m_we_d    = d_wen;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (if_req_eff) begin
                    state_d   = I_BUSY;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = 32'd0;
                end
            end
            D_BUSY, I_BUSY: begin
                if (m_ack) begin
                    state_d = IDLE;
                    m_we_d  = 1'b0;
                    if (live) begin
                        if (state_q == D_BUSY) begin
                            d_ack_d = 1'b1;
                            if (!m_we_q) begin
                                d_rdata_d = m_rdata;
                            end
                        end else begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = m_rdata;
                        end
                    end
                end else if (to_cnt_q + 8'd1 == TO_LIMIT) begin
                    state_d = IDLE;
                    m_we_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    // A flushed requester stays flushed even if it re-raises
                    // its request before this transaction finishes.
                    if (!cur_req) begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            to_cnt_q   <= 8'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            to_cnt_q   <= to_cnt_d;
            drop_q     <= drop_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (if_req && (state_q != I_BUSY) && (d_req_eff || (state_q == D_BUSY))
                && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'd0;
`endif

    assign m_cs      = (state_q != IDLE);
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign mem_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter (ACK_TIMEOUT=4)

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        if_stall;
    logic        mem_stall;
    logic        err;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall), .err(err),
        .conflict_cnt(conflict_cnt)
    );

    // ctl order: {m_cs, m_we, if_ack, d_ack, if_stall, mem_stall, err}
    typedef struct {
        string       name;
        logic        if_req, d_ren, d_wen, m_ack;
        logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
        logic [6:0]  e_ctl;
        logic [31:0] e_addr, e_wdata, e_ir, e_dr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input string nm, input logic i_r, input logic d_r,
                                input logic d_w, input logic [31:0] i_a,
                                input logic [31:0] d_a, input logic [31:0] d_wd,
                                input logic ack, input logic [31:0] rd,
                                input logic [6:0] ctl, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [31:0] eir,
                                input logic [31:0] edr);
        vec_t v;
        v.name = nm; v.if_req = i_r; v.d_ren = d_r; v.d_wen = d_w;
        v.if_addr = i_a; v.d_addr = d_a; v.d_wdata = d_wd;
        v.m_ack = ack; v.m_rdata = rd; v.e_ctl = ctl;
        v.e_addr = ea; v.e_wdata = ewd; v.e_ir = eir; v.e_dr = edr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl_now();
        return {25'd0, m_cs, m_we, if_ack, d_ack, if_stall, mem_stall, err};
    endfunction

    initial begin
        // arbitration: data beats fetch, fetch follows after one IDLE cycle
        tv.push_back(mk("A0", 1,1,0, 32'h40, 32'h200, 0, 0, 0,            7'b0000110, 0,      0, 0, 0));
        tv.push_back(mk("A1", 1,1,0, 32'h40, 32'h200, 0, 1, 32'hAAAA0001, 7'b1000110, 32'h200, 0, 0, 0));
        tv.push_back(mk("A2", 1,1,0, 32'h40, 32'h200, 0, 0, 0,            7'b0001100, 32'h200, 0, 0, 32'hAAAA0001));
        tv.push_back(mk("A3", 1,0,0, 32'h40, 0,       0, 1, 32'hBBBB0002, 7'b1000100, 32'h40,  0, 0, 32'hAAAA0001));
        tv.push_back(mk("A4", 1,0,0, 32'h40, 0,       0, 0, 0,            7'b0010000, 32'h40,  0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("A5", 0,0,0, 0,      0,       0, 1, 32'hFFFFFFFF, 7'b0000000, 32'h40,  0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("A6", 0,0,0, 0,      0,       0, 0, 0,            7'b0000000, 32'h40,  0, 32'hBBBB0002, 32'hAAAA0001));
        // write (ren+wen -> write), ack after 3 busy cycles
        tv.push_back(mk("B0", 0,1,1, 0, 32'h100, 32'hDEADBEEF, 0, 0,            7'b0000010, 32'h40,  0,            32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("B1", 0,1,1, 0, 32'h100, 32'hDEADBEEF, 0, 0,            7'b1100010, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("B2", 0,1,1, 0, 32'h100, 32'hDEADBEEF, 0, 0,            7'b1100010, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("B3", 0,1,1, 0, 32'h100, 32'hDEADBEEF, 1, 32'h55555555, 7'b1100010, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("B4", 0,1,1, 0, 32'h100, 32'hDEADBEEF, 0, 0,            7'b0001000, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("B5", 0,0,0, 0, 0,       0,            0, 0,            7'b0000000, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        // fetch flushed one cycle into I_BUSY
        tv.push_back(mk("C0", 1,0,0, 32'h80, 0, 0, 0, 0,            7'b0000100, 32'h100, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("C1", 0,0,0, 0,      0, 0, 0, 0,            7'b1000000, 32'h80,  0,            32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("C2", 0,0,0, 0,      0, 0, 1, 32'h12345678, 7'b1000000, 32'h80,  0,            32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("C3", 0,0,0, 0,      0, 0, 0, 0,            7'b0000000, 32'h80,  0,            32'hBBBB0002, 32'hAAAA0001));
        // data read dropped mid-transaction
        tv.push_back(mk("D0", 0,1,0, 0, 32'h300, 0, 0, 0,     7'b0000010, 32'h80,  0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("D1", 0,0,0, 0, 0,       0, 0, 0,     7'b1000000, 32'h300, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("D2", 0,0,0, 0, 0,       0, 1, 32'h77, 7'b1000000, 32'h300, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("D3", 0,0,0, 0, 0,       0, 0, 0,     7'b0000000, 32'h300, 0, 32'hBBBB0002, 32'hAAAA0001));
        // timeout after 4 busy cycles
        tv.push_back(mk("E0", 0,1,0, 0, 32'h400, 0, 0, 0, 7'b0000010, 32'h300, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E1", 0,1,0, 0, 32'h400, 0, 0, 0, 7'b1000010, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E2", 0,1,0, 0, 32'h400, 0, 0, 0, 7'b1000010, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E3", 0,1,0, 0, 32'h400, 0, 0, 0, 7'b1000010, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E4", 0,1,0, 0, 32'h400, 0, 0, 0, 7'b1000010, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E5", 0,0,0, 0, 0,       0, 0, 0, 7'b0000001, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));
        tv.push_back(mk("E6", 0,0,0, 0, 0,       0, 0, 0, 7'b0000000, 32'h400, 0, 32'hBBBB0002, 32'hAAAA0001));

        // asynchronous reset, checked before any clock edge acts on it
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl", ctl_now(), 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_ir", if_rdata, 32'd0);
        chk("rst_dr", d_rdata, 32'd0);
        chk("rst_conf", {16'd0, conflict_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            if_req = tv[i].if_req; d_ren = tv[i].d_ren; d_wen = tv[i].d_wen;
            if_addr = tv[i].if_addr; d_addr = tv[i].d_addr; d_wdata = tv[i].d_wdata;
            m_ack = tv[i].m_ack; m_rdata = tv[i].m_rdata;
            #1;
            chk({tv[i].name, "_ctl"}, ctl_now(), {25'd0, tv[i].e_ctl});
            chk({tv[i].name, "_addr"}, m_addr, tv[i].e_addr);
            chk({tv[i].name, "_wdata"}, m_wdata, tv[i].e_wdata);
            chk({tv[i].name, "_ir"}, if_rdata, tv[i].e_ir);
            chk({tv[i].name, "_dr"}, d_rdata, tv[i].e_dr);
        end

        // reset pulsed in D_BUSY: m_cs drops without a clock edge, late ack ignored
        @(negedge clk);
        d_ren = 1'b1; d_addr = 32'h500; m_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("ar_busy_cs", {31'd0, m_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_cs", {31'd0, m_cs}, 32'd0);
        chk("ar_addr", m_addr, 32'd0);
        chk("ar_dr", d_rdata, 32'd0);
        d_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ack = 1'b1; m_rdata = 32'hCAFE0000;
        @(negedge clk);
        m_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ar_post_ctl", ctl_now(), 32'd0);
            chk("ar_post_dr", d_rdata, 32'd0);
            @(negedge clk);
        end

        // conflict counter while fetch waits behind a 3-cycle data read
        if_req = 1'b1; if_addr = 32'h600; d_ren = 1'b1; d_addr = 32'h700;
        @(negedge clk);
        #1;
        chk("cf_daddr", m_addr, 32'h700);
        @(negedge clk);
        #1;
        chk("cf_istall", {31'd0, if_stall}, 32'd1);
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h0BAD0001;
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        chk("cf_dack", {31'd0, d_ack}, 32'd1);
        chk("cf_dr", d_rdata, 32'h0BAD0001);
        d_ren = 1'b0;
        @(negedge clk);
        #1;
        chk("cf_ics", {31'd0, m_cs}, 32'd1);
        chk("cf_iaddr", m_addr, 32'h600);
`ifdef MEM_ARB_PERF_EN
        chk("cf_cnt", {16'd0, conflict_cnt}, 32'd4);
`else
        chk("cf_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
        m_ack = 1'b1; m_rdata = 32'h1F1F1F1F;
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        chk("cf_iack", {31'd0, if_ack}, 32'd1);
        chk("cf_ir", if_rdata, 32'h1F1F1F1F);
        if_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
